// File: rtl/i2c_led_host.sv
`default_nettype none
// ============================================================================
// Module   : i2c_led_host
// Brief    : Single-master I2C write initiator (START, address+W, streamed bytes, STOP)
// Revision : 1.0 - initial release
// ============================================================================
module i2c_led_host #(
  parameter logic [6:0]  ADDRESS = 7'h4A,
  parameter int unsigned CLK_DIV = 50
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       scl_i,
  output logic       scl_o,
  input  logic       sda_i,
  output logic       sda_o,
  input  logic       start_i,
  input  logic [7:0] data_i,
  input  logic       last_i,
  input  logic       data_valid_i,
  output logic       data_ready_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       ack_err_o
);

  localparam int unsigned          C_CNT_W   = $clog2(CLK_DIV);
  localparam logic [C_CNT_W-1:0]   C_CNT_MAX = C_CNT_W'(CLK_DIV - 1);

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_START     = 4'd1,
    S_ADDR      = 4'd2,
    S_ACK_A     = 4'd3,
    S_WAIT_DATA = 4'd4,
    S_DATA      = 4'd5,
    S_ACK_D     = 4'd6,
    S_STOP      = 4'd7,
    S_BUS_FREE  = 4'd8
  } state_t;

  state_t               r_state, w_state_nxt;
  logic [C_CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic [1:0]           r_q, w_q_nxt;
  logic [2:0]           r_bit, w_bit_nxt;
  logic [7:0]           r_shift, w_shift_nxt;
  logic                 r_last, w_last_nxt;
  logic                 r_err, w_err_nxt;
  logic                 r_done, w_done_nxt;

  logic w_bit_state;
  logic w_stretch;
  logic w_qtick;
  logic w_restart;

  assign w_bit_state = (r_state == S_ADDR) || (r_state == S_DATA) ||
                       (r_state == S_ACK_A) || (r_state == S_ACK_D);
  // SCL released in Q2 but still held low by the target: freeze the slot timing
  assign w_stretch   = w_bit_state && (r_q == 2'd2) && !scl_i;
  assign w_qtick     = (r_cnt == C_CNT_MAX) && !w_stretch;
  // Byte accept also restarts the tick so the first Q0 of a data byte is full length
  assign w_restart   = ((r_state == S_IDLE) && start_i) ||
                       ((r_state == S_WAIT_DATA) && data_valid_i);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_q     <= 2'd0;
      r_bit   <= 3'd0;
      r_shift <= 8'd0;
      r_last  <= 1'b0;
      r_err   <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_q     <= w_q_nxt;
      r_bit   <= w_bit_nxt;
      r_shift <= w_shift_nxt;
      r_last  <= w_last_nxt;
      r_err   <= w_err_nxt;
      r_done  <= w_done_nxt;
    end
  end

  always_comb begin
    w_cnt_nxt = r_cnt;
    if (w_restart) begin
      w_cnt_nxt = '0;
    end else if (!w_stretch) begin
      w_cnt_nxt = (r_cnt == C_CNT_MAX) ? '0 : r_cnt + C_CNT_W'(1);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_q_nxt     = r_q;
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    w_last_nxt  = r_last;
    w_err_nxt   = r_err;
    w_done_nxt  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start_i) begin
          w_state_nxt = S_START;
          w_q_nxt     = 2'd0;
          w_bit_nxt   = 3'd0;
          w_shift_nxt = {ADDRESS, 1'b0};
          w_err_nxt   = 1'b0;
        end
      end
      S_START: begin
        if (w_qtick) begin
          if (r_q == 2'd1) begin
            w_state_nxt = S_ADDR;
            w_q_nxt     = 2'd0;
          end else begin
            w_q_nxt = r_q + 2'd1;
          end
        end
      end
      S_ADDR, S_DATA: begin
        if (w_qtick) begin
          w_q_nxt = r_q + 2'd1;
          if (r_q == 2'd3) begin
            w_shift_nxt = {r_shift[6:0], 1'b0};
            w_bit_nxt   = r_bit + 3'd1;
            if (r_bit == 3'd7) begin
              w_state_nxt = (r_state == S_ADDR) ? S_ACK_A : S_ACK_D;
            end
          end
        end
      end
      S_ACK_A, S_ACK_D: begin
        if (w_qtick) begin
          w_q_nxt = r_q + 2'd1;
          if (r_q == 2'd3) begin
            if (sda_i) begin
              w_err_nxt   = 1'b1;
              w_state_nxt = S_STOP;
            end else if ((r_state == S_ACK_D) && r_last) begin
              w_state_nxt = S_STOP;
            end else begin
              w_state_nxt = S_WAIT_DATA;
            end
          end
        end
      end
      S_WAIT_DATA: begin
        if (data_valid_i) begin
          w_shift_nxt = data_i;
          w_last_nxt  = last_i;
          w_state_nxt = S_DATA;
          w_q_nxt     = 2'd0;
          w_bit_nxt   = 3'd0;
        end
      end
      S_STOP: begin
        if (w_qtick) begin
          if (r_q == 2'd2) begin
            w_state_nxt = S_BUS_FREE;
            w_q_nxt     = 2'd0;
          end else begin
            w_q_nxt = r_q + 2'd1;
          end
        end
      end
      S_BUS_FREE: begin
        if (w_qtick) begin
          if (r_q == 2'd3) begin
            w_state_nxt = S_IDLE;
            w_q_nxt     = 2'd0;
            w_done_nxt  = 1'b1;
          end else begin
            w_q_nxt = r_q + 2'd1;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Line levels decoded from state; SCL is low in Q0/Q1 and released in Q2/Q3
  always_comb begin
    scl_o = 1'b1;
    sda_o = 1'b1;
    case (r_state)
      S_START: begin
        sda_o = 1'b0;
      end
      S_ADDR, S_DATA: begin
        scl_o = r_q[1];
        sda_o = r_shift[7];
      end
      S_ACK_A, S_ACK_D: begin
        scl_o = r_q[1];
      end
      S_WAIT_DATA: begin
        scl_o = 1'b0;
      end
      S_STOP: begin
        scl_o = (r_q != 2'd0);
        sda_o = (r_q == 2'd2);
      end
      default: begin
        scl_o = 1'b1;
        sda_o = 1'b1;
      end
    endcase
  end

  assign data_ready_o = (r_state == S_WAIT_DATA);
  assign busy_o       = (r_state != S_IDLE);
  assign done_o       = r_done;
  assign ack_err_o    = r_err;

endmodule
`default_nettype wire

// File: tb/tb_i2c_led_host.sv
`default_nettype none
// ============================================================================
// Module   : tb_i2c_led_host
// Brief    : Self-checking bench with a bus-level I2C target model
// Revision : 1.0 - initial release
// ============================================================================
module tb_i2c_led_host;

  localparam int         CLK_DIV   = 8;
  localparam int         STRETCH   = 300;
  localparam int         WAIT_MAX  = 20000;
  localparam logic [7:0] ADDR_BYTE = 8'h94;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start_i = 1'b0;
  logic [7:0] data_i = 8'h00;
  logic       last_i = 1'b0;
  logic       data_valid_i = 1'b0;
  logic       scl_o, sda_o, data_ready_o, busy_o, done_o, ack_err_o;
  logic       scl_bus, sda_bus;

  // Target model state
  bit         tgt_scl = 1'b1;
  bit         tgt_sda = 1'b1;
  bit         tgt_present = 1'b1;
  int         tgt_nack_idx = -1;
  bit         stretch_en = 1'b0;
  bit         prev_scl = 1'b1;
  bit         prev_sda = 1'b1;
  bit         in_txn = 1'b0;
  bit         have_rise = 1'b0;
  int         cyc = 0;
  int         bitcnt = 0;
  int         byte_idx = 0;
  int         rise_cnt = 0;
  int         last_rise = 0;
  int         per_min = 0;
  int         per_max = 0;
  int         stretch_cnt = 0;
  int         st_phase = 0;
  int         st_fall = 0;
  int         st_rise = 0;
  int         st_low = 0;
  int         st_high = 0;
  int         start_seen = 0;
  int         stop_seen = 0;
  int         done_cnt = 0;
  int         ready_cnt = 0;
  logic [7:0] sr = 8'h00;
  logic [7:0] rx_q[$];

  int         n_tests = 0;
  int         n_fail = 0;
  logic [7:0] pl[$];

  assign scl_bus = scl_o & tgt_scl;
  assign sda_bus = sda_o & tgt_sda;

  always #5 clk = ~clk;

  i2c_led_host #(
    .ADDRESS (7'h4A),
    .CLK_DIV (CLK_DIV)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .scl_i        (scl_bus),
    .scl_o        (scl_o),
    .sda_i        (sda_bus),
    .sda_o        (sda_o),
    .start_i      (start_i),
    .data_i       (data_i),
    .last_i       (last_i),
    .data_valid_i (data_valid_i),
    .data_ready_o (data_ready_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .ack_err_o    (ack_err_o)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Bus-level target: decodes START/STOP and bits from line levels, ACKs on address match
  always @(negedge clk) begin
    bit s_scl, s_sda, ack;
    s_scl = scl_bus;
    s_sda = sda_bus;
    cyc++;
    if (done_o) done_cnt++;
    if (data_ready_o) ready_cnt++;
    if (!rst_n) begin
      tgt_scl     = 1'b1;
      tgt_sda     = 1'b1;
      in_txn      = 1'b0;
      stretch_cnt = 0;
    end else begin
      if (stretch_cnt > 0) begin
        stretch_cnt--;
        if (stretch_cnt == 0) tgt_scl = 1'b1;
      end
      if (prev_scl && s_scl && prev_sda && !s_sda) begin
        start_seen++;
        in_txn    = 1'b1;
        bitcnt    = 0;
        byte_idx  = 0;
        rise_cnt  = 0;
        have_rise = 1'b0;
        per_min   = 32'h7fff_ffff;
        per_max   = 0;
        st_phase  = 0;
        tgt_sda   = 1'b1;
      end else if (prev_scl && s_scl && !prev_sda && s_sda) begin
        stop_seen++;
        in_txn  = 1'b0;
        tgt_sda = 1'b1;
      end else if (in_txn && !prev_scl && s_scl) begin
        rise_cnt++;
        if (have_rise && byte_idx == 0) begin
          if (cyc - last_rise < per_min) per_min = cyc - last_rise;
          if (cyc - last_rise > per_max) per_max = cyc - last_rise;
        end
        last_rise = cyc;
        have_rise = 1'b1;
        if (st_phase == 1) begin
          st_low   = cyc - st_fall;
          st_rise  = cyc;
          st_phase = 2;
        end
        if (bitcnt < 8) begin
          sr = {sr[6:0], s_sda};
          bitcnt++;
        end else begin
          bitcnt = 0;
        end
      end else if (in_txn && prev_scl && !s_scl) begin
        if (st_phase == 2) begin
          st_high  = cyc - st_rise;
          st_phase = 3;
        end
        if (bitcnt == 8) begin
          rx_q.push_back(sr);
          if (byte_idx == 0) ack = tgt_present && (sr == ADDR_BYTE);
          else               ack = ((byte_idx - 1) != tgt_nack_idx);
          tgt_sda = !ack;
          byte_idx++;
        end else begin
          tgt_sda = 1'b1;
        end
        if (stretch_en && byte_idx == 1 && bitcnt == 3 && st_phase == 0) begin
          tgt_scl     = 1'b0;
          stretch_cnt = STRETCH;
          st_fall     = cyc;
          st_phase    = 1;
        end
      end
    end
    prev_scl = s_scl;
    prev_sda = s_sda;
  end

  task automatic run_txn(input bit present, input logic [7:0] payload[$], input int nack_at,
                         input int stall, input bit stretch);
    logic [7:0] exp_q[$];
    int s0, p0, d0, r0, rx0, sent, t, n_exp, bad_stall, bad_rdy, nbytes;
    bit exp_err;
    nbytes       = payload.size();
    tgt_present  = present;
    tgt_nack_idx = nack_at;
    stretch_en   = stretch;
    s0 = start_seen; p0 = stop_seen; d0 = done_cnt; r0 = ready_cnt; rx0 = rx_q.size();
    sent = 0; bad_stall = 0; bad_rdy = 0;
    // start_i together with data_valid_i: the byte must not be taken
    start_i = 1'b1; data_valid_i = 1'b1; data_i = 8'h5A; last_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0; data_valid_i = 1'b0; last_i = 1'b0;
    check_val("busy_after_start", busy_o, 1);
    check_val("err_clear_on_start", ack_err_o, 0);
    for (int i = 0; i < nbytes; i++) begin
      t = 0;
      while (!data_ready_o && busy_o && t < WAIT_MAX) begin
        @(negedge clk);
        t++;
      end
      check_val("ready_wait_bounded", t < WAIT_MAX, 1);
      if (!data_ready_o) break;
      if (i == 0 && stall > 0) begin
        for (int k = 0; k < stall; k++) begin
          if (scl_o !== 1'b0 || data_ready_o !== 1'b1) bad_stall++;
          start_i = (k == stall / 2);
          @(negedge clk);
        end
        start_i = 1'b0;
      end else begin
        repeat ($urandom_range(0, 4)) @(negedge clk);
      end
      data_valid_i = 1'b1;
      data_i       = payload[i];
      last_i       = (i == nbytes - 1);
      @(negedge clk);
      data_valid_i = 1'b0;
      last_i       = 1'b0;
      data_i       = 8'($urandom_range(0, 255));
      if (data_ready_o !== 1'b0) bad_rdy++;
      sent++;
    end
    t = 0;
    while (busy_o && t < WAIT_MAX) begin
      @(negedge clk);
      t++;
    end
    check_val("done_wait_bounded", t < WAIT_MAX, 1);
    repeat (4) @(negedge clk);

    exp_err = !present || (nack_at >= 0 && nack_at < nbytes);
    if (!present)                          n_exp = 0;
    else if (nack_at >= 0 && nack_at < nbytes) n_exp = nack_at + 1;
    else                                   n_exp = nbytes;
    exp_q.push_back(ADDR_BYTE);
    for (int i = 0; i < n_exp; i++) exp_q.push_back(payload[i]);

    check_val("bytes_sent", sent, n_exp);
    check_val("rx_count", rx_q.size() - rx0, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (rx0 + i < rx_q.size()) check_val("rx_byte", rx_q[rx0 + i], exp_q[i]);
    end
    check_val("scl_rises", rise_cnt, 9 * exp_q.size() + 1);
    check_val("ack_err", ack_err_o, exp_err);
    check_val("done_pulses", done_cnt - d0, 1);
    check_val("start_conds", start_seen - s0, 1);
    check_val("stop_conds", stop_seen - p0, 1);
    check_val("ready_seen", ready_cnt != r0, present);
    check_val("ready_drop_after_accept", bad_rdy, 0);
    check_val("scl_period_min", per_min, 4 * CLK_DIV);
    check_val("scl_period_max", per_max, 4 * CLK_DIV);
    check_val("bus_idle", {scl_o, sda_o}, 2'b11);
    if (stall > 0) check_val("stall_hold", bad_stall, 0);
    if (stretch) begin
      check_val("stretch_done", st_phase, 3);
      check_val("stretch_low_in_range", (st_low >= STRETCH - 2) && (st_low <= STRETCH + 5), 1);
      check_val("stretch_high_in_range",
                (st_high >= 2 * CLK_DIV - 2) && (st_high <= 2 * CLK_DIV + 1), 1);
    end
  endtask

  initial begin
    #(90000 * 10);
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t, d0, nb, nk;
    #1;
    check_val("rst_scl", scl_o, 1);
    check_val("rst_sda", sda_o, 1);
    check_val("rst_ready", data_ready_o, 0);
    check_val("rst_busy", busy_o, 0);
    check_val("rst_done", done_o, 0);
    check_val("rst_err", ack_err_o, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Two bytes to a present target
    pl.delete(); pl.push_back(8'hA5); pl.push_back(8'h3C);
    run_txn(1'b1, pl, -1, 0, 1'b0);
    // No target on the bus
    pl.delete(); pl.push_back(8'h11);
    run_txn(1'b0, pl, -1, 0, 1'b0);
    // NACK on the second of three bytes
    pl.delete();
    for (int i = 0; i < 3; i++) pl.push_back(8'($urandom_range(0, 255)));
    run_txn(1'b1, pl, 1, 0, 1'b0);
    // Long stall in WAIT_DATA (also clears the sticky error)
    pl.delete();
    for (int i = 0; i < 2; i++) pl.push_back(8'($urandom_range(0, 255)));
    run_txn(1'b1, pl, -1, 1000, 1'b0);
    // Clock stretch in bit 3 of the first data byte
    pl.delete();
    for (int i = 0; i < 2; i++) pl.push_back(8'($urandom_range(0, 255)));
    run_txn(1'b1, pl, -1, 0, 1'b1);
    // Randomized transactions
    for (int r = 0; r < 6; r++) begin
      nb = $urandom_range(1, 4);
      nk = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, nb - 1)) : -1;
      pl.delete();
      for (int i = 0; i < nb; i++) pl.push_back(8'($urandom_range(0, 255)));
      run_txn($urandom_range(0, 7) != 0, pl, nk, 0, 1'b0);
    end

    // Reset during the DATA phase
    tgt_present = 1'b1; tgt_nack_idx = -1; stretch_en = 1'b0;
    d0 = done_cnt;
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    t = 0;
    while (!data_ready_o && t < WAIT_MAX) begin
      @(negedge clk);
      t++;
    end
    check_val("mid_ready_wait_bounded", t < WAIT_MAX, 1);
    data_valid_i = 1'b1; data_i = 8'hC3; last_i = 1'b1;
    @(negedge clk);
    data_valid_i = 1'b0; last_i = 1'b0;
    repeat (3 * CLK_DIV) @(negedge clk);
    check_val("mid_busy_before_rst", busy_o, 1);
    #2 rst_n = 1'b0;
    #1;
    check_val("mid_rst_scl", scl_o, 1);
    check_val("mid_rst_sda", sda_o, 1);
    check_val("mid_rst_busy", busy_o, 0);
    check_val("mid_rst_ready", data_ready_o, 0);
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (50) @(negedge clk);
    check_val("mid_rst_no_done", done_cnt - d0, 0);
    check_val("mid_rst_idle", busy_o, 0);
    // Recovery after reset
    pl.delete(); pl.push_back(8'h5E);
    run_txn(1'b1, pl, -1, 0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
